// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and the verified operand width.
package seq_mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the high
// half, then shift {carry, acc_hi, acc_lo} right by one bit.
module seq_mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o
);

    // The extra sum bit keeps the carry so the top product bit is never lost.
    logic [WIDTH:0] sum;

    assign sum      = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, multiplicand_i} : '0);
    assign acc_hi_o = sum[WIDTH:1];
    assign acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_mult_32.sv
// Sequential unsigned WIDTH x WIDTH multiplier with valid/ready handshakes.
// Optional macro SEQ_MULT_ZERO_SKIP_EN: zero operands go straight to DONE.
module seq_mult_32
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] step_hi,  step_lo;

    seq_mult_step #(.WIDTH(WIDTH)) u_step (
        .multiplicand_i (mcand_q),
        .acc_hi_i       (acc_hi_q),
        .acc_lo_i       (acc_lo_q),
        .acc_hi_o       (step_hi),
        .acc_lo_o       (step_lo)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    count_d  = '0;
                    state_d  = RUN;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    if (a == '0 || b == '0) begin
                        acc_lo_d = '0;
                        state_d  = DONE;
                    end
`endif
                end
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign product   = {acc_hi_q, acc_lo_q};
    assign overflow  = |acc_hi_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// Self-checking bench for seq_mult_32: directed vector table, backpressure,
// mid-run reset and randomized operands against an arithmetic reference.
module tb_seq_mult_32;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif
    localparam int FULL_LAT = 33;
    localparam int GUARD    = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    seq_mult_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        logic        ovf;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one operation; returns result, overflow and edges from accept to out_valid.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold,
                          input bit scramble, output logic [63:0] prod,
                          output logic ovf, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < GUARD) begin
            @(negedge clk);
            guard++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (!scramble) in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < GUARD) begin
            if (scramble) begin
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check("out_valid_timeout", 64'(guard < GUARD), 64'd1);
        prod = product;
        ovf  = overflow;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_product", product, prod);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_handshake_out_valid", 64'(out_valid), 64'd0);
        check("post_handshake_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] p, exp_p;
        logic        ovf;
        int          lat;
        logic [31:0] ra, rb;

        vecs[0] = '{32'd3,        32'd5,        64'd15,                  1'b0, 0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001,   1'b1, 0};
        vecs[2] = '{32'h00010000, 32'h00010000, 64'h00000001_00000000,   1'b1, 10};
        vecs[3] = '{32'd7,        32'd0,        64'd0,                   1'b0, 0};
        vecs[4] = '{32'd0,        32'd9,        64'd0,                   1'b0, 0};
        vecs[5] = '{32'd1,        32'hFFFFFFFF, 64'h00000000_FFFFFFFF,   1'b0, 0};
        vecs[6] = '{32'h80000000, 32'd2,        64'h00000001_00000000,   1'b1, 0};
        vecs[7] = '{32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE,   1'b1, 2};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].hold, 1'b0, p, ovf, lat);
            check($sformatf("vec%0d_product", i), p, vecs[i].p);
            check($sformatf("vec%0d_overflow", i), 64'(ovf), 64'(vecs[i].ovf));
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'((vecs[i].a == 0 || vecs[i].b == 0) ? ZERO_LAT : FULL_LAT));
        end

        // Reset while RUN is at count 10: accept edge plus ten RUN edges.
        @(negedge clk);
        a = 32'd12345;
        b = 32'd6789;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("midrun_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_out_valid", 64'(out_valid), 64'd0);
        check("midrun_reset_product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrun_release_in_ready", 64'(in_ready), 64'd1);
        check("midrun_release_out_valid", 64'(out_valid), 64'd0);
        run_op(32'd2, 32'd9, 0, 1'b0, p, ovf, lat);
        check("after_reset_product", p, 64'd18);

        // Random operands, scrambled inputs held valid during RUN.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 3) ra = 32'd0;
            exp_p = {32'd0, ra} * {32'd0, rb};
            run_op(ra, rb, $urandom_range(0, 2), 1'b1, p, ovf, lat);
            check($sformatf("rand%0d_product", i), p, exp_p);
            check($sformatf("rand%0d_overflow", i), 64'(ovf), 64'(exp_p[63:32] != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
